hazard_scoreboard_unit: RTL
===========================

# hazard_scoreboard_unit

Parametrised successor to the pipeline's combinational load-use/branch hazard detector. It keeps a per-register scoreboard of in-flight writes as two saturating countdowns:
- **forward-ready:** cycles until the value can be forwarded to EX.
- **writeback-ready:** cycles until the value is readable from the register file in ID.

From these it generates PC/IF-ID stall and ID/EX bubble controls. It sits beside the ID stage, is updated on every ID→EX issue, and supports multi-cycle load latency, a global memory freeze, and a scoreboard clear.

## Interface
- NUM_REGS, 32: architectural registers; register 0 is never scoreboarded.
- REG_AW, $clog2(NUM_REGS): register address width.
- LOAD_LAT, 1: load-use stall cycles for an EX consumer (≥1).
- WB_DIST, 3: stages from EX through WB; branch-in-ID waits this many cycles for an ALU producer.
- CNT_W, $clog2(WB_DIST+LOAD_LAT)+1: countdown width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs, id_rt  in  REG_AW  source registers of the ID instruction.
- id_uses_rs, id_uses_rt  in  1  source actually read.
- id_is_branch  in  1  ID instruction resolves a branch in ID (no forwarding).
- id_reg_write  in  1  ID instruction writes a register.
- id_rd  in  REG_AW  destination register.
- id_mem_read  in  1  ID instruction is a load.
- mem_stall  in  1  data memory not ready; whole pipeline frozen.
- sb_clear  in  1  synchronous clear of all entries (exception/redirect).
- pc_write  out  1  PC may update.
- if_id_write  out  1  IF/ID may update.
- id_ex_flush  out  1  insert a bubble into ID/EX.
- load_use_stall  out  1  EX-consumer hazard active.
- branch_stall  out  1  ID-branch hazard active.
- stall_cycles  out  32  hazard stall counter (see Configuration).

## Operation
- **State:** fwd_cnt[r] and wb_cnt[r], each CNT_W bits, for r = 1..NUM_REGS-1.
  - Entry 0 reads as 0 permanently.
- **Source check:** a source s is checked only when its use flag is set and s≠0.
- **load_use_stall** = id_valid & (any checked source has fwd_cnt ≠ 0).
- **branch_stall** = id_valid & id_is_branch & (any checked source has wb_cnt ≠ 0).
- **hazard** = load_use_stall | branch_stall.
- **pc_write** = if_id_write = !(hazard | mem_stall).
- **id_ex_flush** = hazard & !mem_stall. A frozen pipeline never inserts a bubble.
- **issue** = id_valid & !hazard & !mem_stall.
- **Per-edge update,** in priority order:
  1. sb_clear: all counters ← 0.
  2. mem_stall: all counters hold; issue is blocked.
  3. Otherwise, every nonzero counter decrements by 1. Then, if issue & id_reg_write & id_rd≠0:
     - fwd_cnt[id_rd] ← id_mem_read ? LOAD_LAT : 0
     - wb_cnt[id_rd] ← WB_DIST + (id_mem_read ? LOAD_LAT-1 : 0)
     - The write wins over the same entry's decrement.
- **Bubbles** (flushed or invalid slots) never write the scoreboard.
- **Arithmetic:** counters saturate at 0 and never wrap. CNT_W must hold WB_DIST+LOAD_LAT-1.

## Timing
- **Reset:** all counters and stall_cycles are 0. Outputs are pc_write=1, if_id_write=1, id_ex_flush=0, load_use_stall=0, branch_stall=0.
- **Combinational outputs:** all outputs are combinational from registered counters and the current ID inputs. Zero-cycle decision; no output depends on a same-cycle issue.
- **Load-use:** a load followed by a dependent ALU op stalls exactly LOAD_LAT cycles.
- **Branch after ALU:** a branch after a dependent ALU op stalls WB_DIST cycles.
- **Branch after load:** a branch after a dependent load stalls WB_DIST+LOAD_LAT-1 cycles.
- **mem_stall:** each mem_stall cycle extends an active stall by exactly one cycle.
- **sb_clear with issue:** when both occur in the same cycle, the issued write is discarded.
- **Reset assertion mid-stall:** clears immediately and asynchronously; outputs return to reset values without waiting for clk.

## Configuration
- **HAZ_PERF_CNT_EN defined:** stall_cycles increments each edge where hazard & !mem_stall. It saturates at 2^32-1, clears on reset and on sb_clear, and is otherwise unaffected by mem_stall.
- **HAZ_PERF_CNT_EN undefined:** the counter logic is absent and stall_cycles is constant 0. All other behaviour is identical.

## Test plan
1. **Load-use, LOAD_LAT=1:** issue lw to r8, then add reading r8 via rs → exactly 1 cycle with pc_write=0 and id_ex_flush=1. The add issues on the next cycle; stall_cycles=1.
2. **Load-use, LOAD_LAT=3:** same sequence → 3 stall cycles. Then r0 as destination/source → no stall ever.
3. **Branch after ALU:** add r5, then beq reading r5 (WB_DIST=3) → branch_stall for 3 cycles. A beq issued 4 cycles after the add does not stall.
4. **mem_stall during stall:** lw r8; dependent use; assert mem_stall for 2 cycles during the stall → counters hold; pc_write=0 and id_ex_flush=0 while frozen. Total stall = 1+2 cycles.
5. **sb_clear:** with wb_cnt[r5]=2, pulse sb_clear → the next cycle's branch on r5 does not stall, and stall_cycles=0.
6. **Reset mid-stall:** assert rst_n=0 mid-stall → all outputs take reset values within the same cycle; the scoreboard is empty after release.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_unit
//
// Purpose:
//   Scoreboard-based hazard detector that sits beside the ID stage. Every
//   in-flight register write is tracked with two saturating countdowns:
//     fwdCnt[r] : cycles until the value can be forwarded into EX
//     wbCnt[r]  : cycles until the value is readable from the register file
//   The counters drive PC/IF-ID stall and ID/EX bubble controls. The unit
//   supports multi-cycle load latency, a global memory freeze (mem_stall)
//   and a synchronous scoreboard clear (sb_clear).
//
// Optional feature (compile-time macro):
//   HAZ_PERF_CNT_EN  when defined, stall_cycles counts every clock edge on
//                    which a hazard bubble is inserted (saturating, cleared
//                    by reset and sb_clear). When undefined, stall_cycles
//                    is tied to 0 and no counter logic exists.
//
// Ports:
//   clk             in   clock, all state updates on the rising edge
//   rst_n           in   asynchronous active-low reset
//   id_valid        in   IF/ID holds a real instruction
//   id_rs, id_rt    in   source registers of the ID instruction
//   id_uses_rs/rt   in   the corresponding source is actually read
//   id_is_branch    in   ID instruction resolves a branch in ID
//   id_reg_write    in   ID instruction writes a register
//   id_rd           in   destination register
//   id_mem_read     in   ID instruction is a load
//   mem_stall       in   data memory not ready, whole pipeline frozen
//   sb_clear        in   synchronous clear of all scoreboard entries
//   pc_write        out  PC may update
//   if_id_write     out  IF/ID may update
//   id_ex_flush     out  insert a bubble into ID/EX
//   load_use_stall  out  EX-consumer hazard active
//   branch_stall    out  ID-branch hazard active
//   stall_cycles    out  hazard stall counter (0 unless HAZ_PERF_CNT_EN)
// ---------------------------------------------------------------------------
module hazard_scoreboard_unit #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = $clog2(NUM_REGS),
  parameter int LOAD_LAT = 1,
  parameter int WB_DIST  = 3,
  parameter int CNT_W    = $clog2(WB_DIST + LOAD_LAT) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              id_reg_write,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_mem_read,
  input  logic              mem_stall,
  input  logic              sb_clear,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_flush,
  output logic              load_use_stall,
  output logic              branch_stall,
  output logic [31:0]       stall_cycles
);

  // The tables are sized to the full address space so that any source or
  // destination address indexes a real entry; entries 0 and those at or
  // above NUM_REGS are never written and therefore always read as zero.
  localparam int DEPTH = 1 << REG_AW;

  localparam logic [CNT_W-1:0] FWD_LOAD = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] WB_ALU   = CNT_W'(WB_DIST);
  localparam logic [CNT_W-1:0] WB_LOAD  = CNT_W'(WB_DIST + LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] fwdCnt  [DEPTH];
  logic [CNT_W-1:0] wbCnt   [DEPTH];
  logic [CNT_W-1:0] fwdNext [DEPTH];
  logic [CNT_W-1:0] wbNext  [DEPTH];

  logic rsChecked;
  logic rtChecked;
  logic rsFwdBusy;
  logic rtFwdBusy;
  logic rsWbBusy;
  logic rtWbBusy;
  logic loadUseHaz;
  logic branchHaz;
  logic hazard;
  logic issue;
  logic sbWrite;

  // A source only matters when the instruction really reads it; register 0
  // is hard-wired and can never carry a dependency.
  assign rsChecked = id_uses_rs && (id_rs != '0);
  assign rtChecked = id_uses_rt && (id_rt != '0);

  assign rsFwdBusy = rsChecked && (fwdCnt[id_rs] != '0);
  assign rtFwdBusy = rtChecked && (fwdCnt[id_rt] != '0);
  assign rsWbBusy  = rsChecked && (wbCnt[id_rs] != '0);
  assign rtWbBusy  = rtChecked && (wbCnt[id_rt] != '0);

  // An EX consumer only needs the value to be forwardable, while a branch
  // resolved in ID has no forwarding path and must wait for writeback.
  assign loadUseHaz = id_valid && (rsFwdBusy || rtFwdBusy);
  assign branchHaz  = id_valid && id_is_branch && (rsWbBusy || rtWbBusy);
  assign hazard     = loadUseHaz || branchHaz;

  // Only a real, non-stalled instruction in an unfrozen pipeline issues;
  // bubbles and held slots never touch the scoreboard.
  assign issue   = id_valid && !hazard && !mem_stall;
  assign sbWrite = issue && id_reg_write && (id_rd != '0);

  // Stall/bubble controls are purely combinational from the registered
  // counters and the current ID inputs. A frozen pipeline holds everything
  // in place, so it stalls the front end but never injects a bubble.
  assign load_use_stall = loadUseHaz;
  assign branch_stall   = branchHaz;
  assign pc_write       = !(hazard || mem_stall);
  assign if_id_write    = !(hazard || mem_stall);
  assign id_ex_flush    = hazard && !mem_stall;

  // Next-state computation for every scoreboard entry. Clear beats freeze,
  // freeze beats the normal countdown, and a new issue to an entry replaces
  // that entry's own decrement in the same cycle. Counters stop at zero.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      fwdNext[r] = '0;
      wbNext[r]  = '0;
    end
    for (int r = 1; r < DEPTH; r++) begin
      if (r < NUM_REGS) begin
        if (sb_clear) begin
          fwdNext[r] = '0;
          wbNext[r]  = '0;
        end else if (mem_stall) begin
          fwdNext[r] = fwdCnt[r];
          wbNext[r]  = wbCnt[r];
        end else begin
          fwdNext[r] = (fwdCnt[r] != '0) ? (fwdCnt[r] - CNT_ONE) : '0;
          wbNext[r]  = (wbCnt[r] != '0) ? (wbCnt[r] - CNT_ONE) : '0;
          if (sbWrite && (id_rd == REG_AW'(r))) begin
            fwdNext[r] = id_mem_read ? FWD_LOAD : '0;
            wbNext[r]  = id_mem_read ? WB_LOAD : WB_ALU;
          end
        end
      end
    end
  end

  // Scoreboard register file. Reset empties it immediately so that all
  // outputs return to their idle values without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        fwdCnt[r] <= '0;
        wbCnt[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        fwdCnt[r] <= fwdNext[r];
        wbCnt[r]  <= wbNext[r];
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stallCount;

  // Counts edges on which a hazard bubble is actually inserted. Frozen
  // cycles do not count because no bubble enters ID/EX then. The counter
  // sticks at all-ones instead of wrapping, and is emptied by sb_clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCount <= '0;
    end else if (sb_clear) begin
      stallCount <= '0;
    end else if (hazard && !mem_stall && (stallCount != '1)) begin
      stallCount <= stallCount + 32'd1;
    end
  end

  assign stall_cycles = stallCount;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
